mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter ADDR_W SHALL default to 18 and set the width of all address ports.
REQ-002 The parameter DATA_W SHALL default to 16 and set the width of all data ports.
REQ-003 The parameter ACK_TIMEOUT SHALL default to 256 and set the cycle limit for controller acceptance.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  asynchronous reset, active-low.
REQ-007 if_req  in  1  instruction-fetch read request, held by the requester until if_valid.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rdata  out  DATA_W  fetched word.
REQ-010 if_valid  out  1  one-cycle fetch completion pulse.
REQ-011 dm_rd / dm_wr  in  1 each  data-memory read / write request, held until dm_valid.
REQ-012 dm_addr  in  ADDR_W  data address.
REQ-013 dm_wdata  in  DATA_W  data to write.
REQ-014 dm_rdata  out  DATA_W  data read result.
REQ-015 dm_valid  out  1  one-cycle data completion pulse.
REQ-016 stall  out  1  pipeline stall, combinational.
REQ-017 mc_need / mc_rd / mc_wr  out  1 each  job request and type to the shared RAM/UART controller.
REQ-018 mc_addr  out  ADDR_W  controller address.
REQ-019 mc_wdata  out  DATA_W  controller write data.
REQ-020 mc_done  in  1  controller work-done level; it drops when a job is accepted and rises when the job completes.
REQ-021 mc_result  in  DATA_W  controller read data, valid while mc_done=1 after completion.
REQ-022 err_timeout  out  1  sticky acceptance-timeout flag.

Function
REQ-023 The FSM SHALL have three states, IDLE, ACK and BUSY, plus a registered owner bit (DM or IF).
REQ-024 In IDLE, if dm_rd|dm_wr is high, the block SHALL latch dm_addr, dm_wdata and the operation, set owner=DM and go to ACK.
REQ-025 In IDLE with no data request and if_req high, the block SHALL latch if_addr as a read, set owner=IF and go to ACK.
REQ-026 Data requests SHALL have fixed priority over fetch, and the arbiter SHALL hold only one job at a time.
REQ-027 When dm_rd and dm_wr are both high, the job SHALL be a write: mc_wr=1 and mc_rd=0.
REQ-028 mc_need SHALL be high only in ACK, and mc_addr, mc_wdata, mc_rd and mc_wr SHALL come from the latch and stay stable in both ACK and BUSY.
REQ-029 In ACK, the block SHALL go to BUSY on the first edge that samples mc_done=0.
REQ-030 In BUSY, on the first edge that samples mc_done=1, the block SHALL go to IDLE and register a one-cycle pulse on the owner's valid.
REQ-031 On completion of a read, the owner's rdata SHALL register mc_result on the same edge; on completion of a write, dm_rdata SHALL be unchanged.
REQ-032 if_rdata and dm_rdata SHALL hold their value until the next read by the same owner.
REQ-033 Minimum latency SHALL be: request sampled at edge 0, ACK exits at edge 1, BUSY exits at edge 2, valid high during the cycle after edge 2.
REQ-034 From the cycle valid is high, the block SHALL take one IDLE cycle before the next grant.
REQ-035 stall SHALL equal ((dm_rd|dm_wr) & ~dm_valid) | (if_req & ~if_valid).
REQ-036 An ACK-wait counter SHALL clear on entry to ACK and saturate at ACK_TIMEOUT.
REQ-037 When the counter reaches ACK_TIMEOUT, err_timeout SHALL set and remain set until reset, while the FSM keeps waiting in ACK.
REQ-038 A request that drops while its job is in ACK or BUSY SHALL not abort the job; the valid pulse SHALL still be issued.

Reset
REQ-039 While rst=0, state SHALL be IDLE and owner SHALL be IF.
REQ-040 While rst=0, mc_need, mc_rd, mc_wr, if_valid, dm_valid and err_timeout SHALL be 0.
REQ-041 While rst=0, mc_addr, mc_wdata, if_rdata and dm_rdata SHALL be 0.
REQ-042 Reset asserted during ACK or BUSY SHALL discard the job with no valid pulse, and the block SHALL re-arbitrate from IDLE after release.

Verification
REQ-043 The bench SHALL cover reset: assert rst mid-BUSY -> all outputs 0 next sample, no valid pulse, and the next if_req is served normally.
REQ-044 The bench SHALL cover a single fetch: if_req with if_addr=0x0040, model drops mc_done 1 cycle later, raises it 3 cycles later with mc_result=0x1234 -> mc_rd=1, mc_wr=0, one if_valid pulse, if_rdata=0x1234.
REQ-045 The bench SHALL cover a simultaneous request: dm_wr (0x0BF00, 0x0041) with if_req (0x0041) -> DM job first (mc_wr=1, mc_addr=0x0BF00), then the IF job; stall high until if_valid.
REQ-046 The bench SHALL cover a conflicting request: dm_rd=dm_wr=1 -> write issued and dm_rdata unchanged.
REQ-047 The bench SHALL cover timeout: mc_done held high 300 cycles in ACK -> err_timeout=1 from cycle 256, job completes when mc_done toggles, and the flag stays high.
REQ-048 The bench SHALL cover back-to-back requests: dm_rd then if_req -> exactly one IDLE cycle between dm_valid and the next mc_need.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM/UART controller between the data-memory port
// and the instruction-fetch port. Data requests win over fetch, and only one
// job is in flight at a time.
//
// Controller handshake: mc_need is raised in ACK. The controller accepts the
// job by dropping mc_done, and completes it by raising mc_done again, with
// mc_result valid while mc_done=1. Each requester holds its request until its
// one-cycle valid pulse, and the arbiter does not grant while a valid pulse is
// out. This keeps a held request from being served twice.
module mem_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall,
  output logic              mc_need,
  output logic              mc_rd,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_result,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              lat_rd;
  logic              lat_wr;
  logic [CNT_W-1:0]  ack_cnt;
  logic              dm_req;
  logic              grant;
  logic              done_ev;

  assign dm_req = dm_rd | dm_wr;

  // Pipeline stall: a request is outstanding and its completion pulse is not out.
  assign stall = (dm_req & ~dm_valid) | (if_req & ~if_valid);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. IDLE refuses to grant while a valid pulse is out.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if ((dm_req | if_req) && !if_valid && !dm_valid) state_nxt = S_ACK;
      S_ACK:  if (!mc_done) state_nxt = S_BUSY;
      S_BUSY: if (mc_done)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and internal strobes.
  always_comb begin
    mc_need = (state == S_ACK);
    mc_rd   = lat_rd & (state != S_IDLE);
    mc_wr   = lat_wr & (state != S_IDLE);
    grant   = (state == S_IDLE) && (state_nxt == S_ACK);
    done_ev = (state == S_BUSY) && mc_done;
  end

  // Job latch: captured on grant and held through ACK and BUSY. When both
  // dm_rd and dm_wr are set, the job is a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= OWN_IF;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      mc_addr  <= '0;
      mc_wdata <= '0;
    end else if (grant) begin
      if (dm_req) begin
        owner    <= OWN_DM;
        lat_rd   <= dm_rd & ~dm_wr;
        lat_wr   <= dm_wr;
        mc_addr  <= dm_addr;
        mc_wdata <= dm_wdata;
      end else begin
        owner    <= OWN_IF;
        lat_rd   <= 1'b1;
        lat_wr   <= 1'b0;
        mc_addr  <= if_addr;
      end
    end
  end

  // Completion: pulse the owner's valid flag and capture read data. Each
  // rdata register holds until the next read by the same owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= done_ev && (owner == OWN_IF);
      dm_valid <= done_ev && (owner == OWN_DM);
      if (done_ev && lat_rd) begin
        if (owner == OWN_IF) if_rdata <= mc_result;
        else                 dm_rdata <= mc_result;
      end
    end
  end

  // ACK-wait counter and sticky timeout flag. The flag sets on the same edge
  // the counter reaches ACK_TIMEOUT. The FSM keeps waiting in ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (grant) begin
        ack_cnt <= '0;
      end else if (state == S_ACK && ack_cnt != TMO) begin
        ack_cnt <= ack_cnt + CNT_W'(1);
      end
      if (state == S_ACK && ack_cnt >= TMO_M1) err_timeout <= 1'b1;
    end
  end

endmodule
